// File: rtl/xtea_arbiter.sv
// Round-robin arbiter sharing one XTEA core between NUM_REQ requesters.
// One operation in flight at a time: grant in IDLE, start pulse in ISSUE,
// result or timeout in WAIT, and a held response in RESP.
module xtea_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [64*NUM_REQ-1:0]  req_data_i,
    input  logic [128*NUM_REQ-1:0] req_key_i,
    input  logic [NUM_REQ-1:0]     req_decrypt_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [2:0]             rsp_id_o,
    output logic [63:0]            rsp_data_o,
    output logic                   rsp_err_o,
    output logic                   core_valid_o,
    output logic                   core_en_o,
    output logic [63:0]            core_data_o,
    output logic [127:0]           core_key_o,
    output logic                   core_decrypt_o,
    input  logic [63:0]            core_result_i,
    input  logic                   core_valid_i,
    input  logic                   core_busy_i
);
    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Packed per-requester views of the flat request buses.
    logic [NUM_REQ-1:0][63:0]  req_data_arr;
    logic [NUM_REQ-1:0][127:0] req_key_arr;
    assign req_data_arr = req_data_i;
    assign req_key_arr  = req_key_i;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             grant;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    logic [IDX_W-1:0] op_id;
    logic [15:0]      wait_cnt;
    logic             wait_done;

    assign wait_done = (wait_cnt == WAIT_LAST);

    // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand_sum > {1'b0, LAST_IDX})
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            cand = cand_sum[IDX_W-1:0];
            if (!gnt_any && req_valid_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Ready is combinational off req_valid_i, so reset gates it directly to
    // keep every output low while rst_i is high.
    assign grant = (state == IDLE) && gnt_any && !core_busy_i && !rst_i;

    // State register.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt    = state;
        req_ready_o  = '0;
        rsp_valid_o  = 1'b0;
        core_valid_o = 1'b0;
        core_en_o    = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    state_nxt            = ISSUE;
                end
            end
            ISSUE: begin
                core_valid_o = 1'b1;
                core_en_o    = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                core_en_o = 1'b1;
                if (core_valid_i || wait_done) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot the granted request so later input changes cannot disturb it.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            core_data_o    <= '0;
            core_key_o     <= '0;
            core_decrypt_o <= 1'b0;
            op_id          <= '0;
        end else if (grant) begin
            core_data_o    <= req_data_arr[gnt_idx];
            core_key_o     <= req_key_arr[gnt_idx];
            core_decrypt_o <= req_decrypt_i[gnt_idx];
            op_id          <= gnt_idx;
        end
    end

    // Wait counter: zeroed while issuing, counts cycles spent in WAIT.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i)               wait_cnt <= '0;
        else if (state == ISSUE) wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + 16'd1;
    end

    // Response capture; a core result beats a timeout in the same cycle.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
        end else if (state == WAIT) begin
            if (core_valid_i) begin
                rsp_data_o <= core_result_i;
                rsp_err_o  <= 1'b0;
            end else if (wait_done) begin
                rsp_data_o <= '0;
                rsp_err_o  <= 1'b1;
            end
        end
    end

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i)
            rr_ptr <= '0;
        else if (state == RESP && rsp_ready_i)
            rr_ptr <= (op_id == LAST_IDX) ? '0 : op_id + IDX_W'(1);
    end

    assign rsp_id_o = 3'(op_id);

endmodule

// File: tb/tb_xtea_arbiter.sv
// Directed bench for xtea_arbiter: a main instance (TIMEOUT=255) driven by a
// 10-cycle data^key core stub, and a TIMEOUT=8 instance with a hand-driven core.
module tb_xtea_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    always #5 clk = ~clk;

    // main instance
    logic [3:0]   req_valid, req_dec, req_ready;
    logic [255:0] req_data;
    logic [511:0] req_key;
    logic         rsp_valid, rsp_ready, rsp_err;
    logic [2:0]   rsp_id;
    logic [63:0]  rsp_data;
    logic         core_valid, core_en, core_dec;
    logic [63:0]  core_data, core_result;
    logic [127:0] core_key;
    logic         core_vld_in, core_busy;

    // stub and injection
    logic [3:0]   stub_cnt;
    logic         stub_vld, stub_busy;
    logic [63:0]  stub_acc, stub_res;
    logic         inj_valid, force_busy;
    logic [63:0]  inj_result;

    assign core_vld_in = stub_vld | inj_valid;
    assign core_result = inj_valid ? inj_result : stub_res;
    assign core_busy   = stub_busy | force_busy;

    // timeout instance
    logic [3:0]   t_req_valid, t_req_dec, t_req_ready;
    logic [255:0] t_req_data;
    logic [511:0] t_req_key;
    logic         t_rsp_valid, t_rsp_ready, t_rsp_err;
    logic [2:0]   t_rsp_id;
    logic [63:0]  t_rsp_data;
    logic         t_core_valid, t_core_en, t_core_dec;
    logic [63:0]  t_core_data, t_core_result;
    logic [127:0] t_core_key;
    logic         t_core_vld_in, t_core_busy;

    xtea_arbiter #(.NUM_REQ(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_key_i(req_key),
        .req_decrypt_i(req_dec), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .core_valid_o(core_valid), .core_en_o(core_en), .core_data_o(core_data),
        .core_key_o(core_key), .core_decrypt_o(core_dec),
        .core_result_i(core_result), .core_valid_i(core_vld_in), .core_busy_i(core_busy)
    );

    xtea_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut_t8 (
        .clk(clk), .rst_i(rst),
        .req_valid_i(t_req_valid), .req_data_i(t_req_data), .req_key_i(t_req_key),
        .req_decrypt_i(t_req_dec), .req_ready_o(t_req_ready),
        .rsp_valid_o(t_rsp_valid), .rsp_ready_i(t_rsp_ready), .rsp_id_o(t_rsp_id),
        .rsp_data_o(t_rsp_data), .rsp_err_o(t_rsp_err),
        .core_valid_o(t_core_valid), .core_en_o(t_core_en), .core_data_o(t_core_data),
        .core_key_o(t_core_key), .core_decrypt_o(t_core_dec),
        .core_result_i(t_core_result), .core_valid_i(t_core_vld_in), .core_busy_i(t_core_busy)
    );

    // Core stub: result = data ^ key[63:0], valid 10 cycles after the start pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_cnt  <= '0;
            stub_vld  <= 1'b0;
            stub_busy <= 1'b0;
            stub_acc  <= '0;
            stub_res  <= '0;
        end else begin
            stub_vld <= 1'b0;
            if (core_valid) begin
                stub_cnt  <= 4'd10;
                stub_busy <= 1'b1;
                stub_acc  <= core_data ^ core_key[63:0];
            end else if (stub_cnt != 4'd0) begin
                stub_cnt <= stub_cnt - 4'd1;
                if (stub_cnt == 4'd1) begin
                    stub_vld  <= 1'b1;
                    stub_busy <= 1'b0;
                    stub_res  <= stub_acc;
                end
            end
        end
    end

    // Grant log: ready vector of every grant cycle, in order.
    logic [3:0] grant_log [$];
    always @(posedge clk) if (req_ready != 4'd0) grant_log.push_back(req_ready);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        chk(tag, rsp_valid, 1'b1);
    endtask

    task automatic set_req(input int n, input logic [63:0] d, input logic [127:0] k, input logic dec);
        req_data[64*n +: 64] = d;
        req_key[128*n +: 128] = k;
        req_dec[n]            = dec;
    endtask

    logic [63:0]  dv [4];
    logic [127:0] kv [4];
    logic [3:0]   exp_g [6];
    logic [3:0]   g;
    int           n;

    initial begin
        dv = '{64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002,
               64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004};
        kv = '{{64'hAAAA_0000_0000_0000, 64'h0000_0000_0000_00F0},
               {64'hBBBB_0000_0000_0000, 64'h0000_0000_0000_0F00},
               {64'hCCCC_0000_0000_0000, 64'h0000_0000_0000_F000},
               {64'hDDDD_0000_0000_0000, 64'h0000_0000_000F_0000}};
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        rst = 1'b1;
        req_valid = 4'hF; req_dec = '0; req_data = '0; req_key = '0;
        rsp_ready = 1'b0; inj_valid = 1'b0; inj_result = '0; force_busy = 1'b0;
        t_req_valid = '0; t_req_dec = '0; t_req_data = '0; t_req_key = '0;
        t_rsp_ready = 1'b0; t_core_vld_in = 1'b0; t_core_result = '0; t_core_busy = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, dv[i], kv[i], 1'b0);

        // reset state, with every requester asserting valid
        cyc();
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 3'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_core_valid", core_valid, 1'b0);
        chk("rst_core_en", core_en, 1'b0);
        chk("rst_core_data", core_data, 64'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_core_dec", core_dec, 1'b0);
        cyc();
        req_valid = 4'b0000;
        rst = 1'b0;

        // single request from requester 2
        set_req(2, 64'h0123456789ABCDEF, {64'h0BAD_CAFE_0BAD_CAFE, 64'hFFFF0000FFFF0000}, 1'b1);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        cyc();
        req_valid = 4'b0000;
        set_req(2, 64'hDEAD_DEAD_DEAD_DEAD, 128'h1, 1'b0);
        #1;
        chk("single_ready_drop", req_ready, 4'b0000);
        chk("single_core_valid", core_valid, 1'b1);
        chk("single_core_en", core_en, 1'b1);
        chk("single_core_data", core_data, 64'h0123456789ABCDEF);
        chk("single_core_key", core_key, {64'h0BAD_CAFE_0BAD_CAFE, 64'hFFFF0000FFFF0000});
        chk("single_core_dec", core_dec, 1'b1);
        cyc();
        chk("single_core_valid_1cyc", core_valid, 1'b0);
        chk("single_wait_en", core_en, 1'b1);
        wait_rsp("single_rsp_valid");
        chk("single_rsp_id", rsp_id, 3'd2);
        chk("single_rsp_data", rsp_data, 64'hFEDC45677654CDEF);
        chk("single_rsp_err", rsp_err, 1'b0);

        // backpressure: hold RESP 20 cycles with another request pending and
        // a stray core_valid pulse that must be ignored
        req_valid = 4'b1000;
        inj_result = 64'h5555_AAAA_5555_AAAA;
        for (int i = 0; i < 20; i++) begin
            inj_valid = (i == 5);
            #1;
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 64'hFEDC45677654CDEF);
            chk("bp_no_ready", req_ready, 4'b0000);
            cyc();
        end
        inj_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("bp_hold_until_edge", rsp_valid, 1'b1);
        cyc();
        chk("bp_rsp_fall", rsp_valid, 1'b0);
        chk("bp_next_grant", req_ready, 4'b1000);
        cyc();
        req_valid = 4'b0000;
        wait_rsp("req3_rsp_valid");
        chk("req3_rsp_id", rsp_id, 3'd3);
        chk("req3_rsp_data", rsp_data, dv[3] ^ kv[3][63:0]);
        cyc();

        // fairness: all four held valid from rr_ptr = 0
        grant_log.delete();
        req_valid = 4'hF;
        n = 0;
        while (grant_log.size() < 6 && n < 300) begin
            cyc();
            n++;
        end
        req_valid = 4'b0000;
        chk("fair_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            g = (i < grant_log.size()) ? grant_log[i] : 4'bxxxx;
            chk($sformatf("fair_grant%0d", i), g, exp_g[i]);
        end
        wait_rsp("fair_rsp_valid");
        chk("fair_last_id", rsp_id, 3'd1);
        cyc();

        // busy core blocks grants
        force_busy = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("busy_no_grant", req_ready, 4'b0000);
            cyc();
        end
        force_busy = 1'b0;
        #1;
        chk("busy_release_grant", req_ready, 4'b0001);
        cyc();

        // reset three cycles into the operation
        req_valid = 4'hF;
        #1;
        chk("rstw_issue", core_valid, 1'b1);
        chk("rstw_core_data", core_data, dv[0]);
        cyc(); cyc(); cyc();
        chk("rstw_in_wait", core_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstw_ready", req_ready, 4'b0000);
        chk("rstw_rsp_valid", rsp_valid, 1'b0);
        chk("rstw_core_en", core_en, 1'b0);
        chk("rstw_core_valid", core_valid, 1'b0);
        chk("rstw_core_key", core_key, 128'd0);
        chk("rstw_rsp_data", rsp_data, 64'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rstw_first_grant", req_ready, 4'b0001);
        chk("rstw_no_rsp", rsp_valid, 1'b0);
        cyc();
        req_valid = 4'b0000;
        wait_rsp("rstw_rsp_valid");
        chk("rstw_rsp_id", rsp_id, 3'd0);
        chk("rstw_rsp_data", rsp_data, dv[0] ^ kv[0][63:0]);
        cyc();

        // TIMEOUT=8 instance: result arriving on the timeout cycle wins
        t_req_data[63:0] = 64'h0F0F_0F0F_0F0F_0F0F;
        t_req_data[255:192] = 64'h7777_7777_7777_7777;
        t_req_valid = 4'b0001;
        #1;
        chk("t8_ready0", t_req_ready, 4'b0001);
        cyc();
        t_req_valid = 4'b0000;
        #1;
        chk("t8_issue0", t_core_valid, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("t8_still_waiting", t_rsp_valid, 1'b0);
        end
        t_core_vld_in = 1'b1;
        t_core_result = 64'hC0FFEE00_12345678;
        cyc();
        t_core_vld_in = 1'b0;
        #1;
        chk("t8_edge_rsp_valid", t_rsp_valid, 1'b1);
        chk("t8_edge_err", t_rsp_err, 1'b0);
        chk("t8_edge_data", t_rsp_data, 64'hC0FFEE00_12345678);
        chk("t8_edge_id", t_rsp_id, 3'd0);
        t_rsp_ready = 1'b1;
        cyc();
        t_rsp_ready = 1'b0;

        // TIMEOUT=8 instance: core never answers
        t_req_valid = 4'b1000;
        #1;
        chk("t8_ready3", t_req_ready, 4'b1000);
        cyc();
        t_req_valid = 4'b0000;
        n = 0;
        while (t_rsp_valid !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        chk("t8_timeout_latency", n, 9);
        chk("t8_timeout_err", t_rsp_err, 1'b1);
        chk("t8_timeout_data", t_rsp_data, 64'd0);
        chk("t8_timeout_id", t_rsp_id, 3'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
